// File: rtl/hpdcache_mem_resp_upsizer.sv
// Memory read-response upsizer: gathers consecutive narrow response beats of one
// transaction into full cache-line words. It has one accumulator slot for the word
// being built and one output register that drives the mem_resp_read_* port.
//
// Handshakes: a beat transfers on bus_rsp_valid_i & bus_rsp_ready_o. A word transfers
// on mem_resp_read_valid_o & mem_resp_read_ready_i. Once valid is raised, it stays high
// and its payload stays stable until the matching ready is seen. Neither side's ready
// depends combinationally on its own valid.
module hpdcache_mem_resp_upsizer #(
  parameter int unsigned IN_DATA_WIDTH  = 128,
  parameter int unsigned OUT_DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH       = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      bus_rsp_valid_i,
  output logic                      bus_rsp_ready_o,
  input  logic [IN_DATA_WIDTH-1:0]  bus_rsp_data_i,
  input  logic [ID_WIDTH-1:0]       bus_rsp_id_i,
  input  logic                      bus_rsp_error_i,
  input  logic                      bus_rsp_last_i,
  output logic                      mem_resp_read_valid_o,
  input  logic                      mem_resp_read_ready_i,
  output logic [OUT_DATA_WIDTH-1:0] mem_resp_read_data_o,
  output logic [ID_WIDTH-1:0]       mem_resp_read_id_o,
  output logic                      mem_resp_read_error_o,
  output logic                      mem_resp_read_last_o
);

  localparam int unsigned RATIO = OUT_DATA_WIDTH / IN_DATA_WIDTH;
  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  // FILL: accepting beats. WAIT: a finished word is parked in the accumulator
  // behind a stalled output register.
  typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [OUT_DATA_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [ID_WIDTH-1:0]       acc_id_q, acc_id_d;
  logic                      acc_err_q, acc_err_d;
  logic                      acc_last_q, acc_last_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]       out_id_q, out_id_d;
  logic                      out_err_q, out_err_d;
  logic                      out_last_q, out_last_d;

  logic                      beat_fire;
  logic                      out_fire;
  logic                      out_free;
  logic                      complete;
  logic [OUT_DATA_WIDTH-1:0] merged_data;
  logic [ID_WIDTH-1:0]       merged_id;
  logic                      merged_err;

  assign bus_rsp_ready_o       = (state_q == FILL);
  assign beat_fire             = bus_rsp_valid_i & bus_rsp_ready_o;
  assign out_fire              = out_valid_q & mem_resp_read_ready_i;
  assign out_free              = ~out_valid_q | mem_resp_read_ready_i;

  assign mem_resp_read_valid_o = out_valid_q;
  assign mem_resp_read_data_o  = out_data_q;
  assign mem_resp_read_id_o    = out_id_q;
  assign mem_resp_read_error_o = out_err_q;
  assign mem_resp_read_last_o  = out_last_q;

  // Merge the incoming beat into the word under construction. Lane 0 restarts
  // from zero, so lanes that a short transaction never writes stay at zero.
  always_comb begin
    merged_data = (cnt_q == '0) ? '0 : acc_data_q;
    merged_data[cnt_q*IN_DATA_WIDTH +: IN_DATA_WIDTH] = bus_rsp_data_i;
    merged_id   = (cnt_q == '0) ? bus_rsp_id_i : acc_id_q;
    merged_err  = ((cnt_q != '0) & acc_err_q) | bus_rsp_error_i;
    complete    = (cnt_q == LAST_LANE) | bus_rsp_last_i;
  end

  // Next-state and register updates for the accumulator, output slot and FSM.
  always_comb begin
    state_d     = state_q;
    acc_data_d  = acc_data_q;
    acc_id_d    = acc_id_q;
    acc_err_d   = acc_err_q;
    acc_last_d  = acc_last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (beat_fire) begin
          if (complete) begin
            cnt_d = '0;
            if (out_free) begin
              out_valid_d = 1'b1;
              out_data_d  = merged_data;
              out_id_d    = merged_id;
              out_err_d   = merged_err;
              out_last_d  = bus_rsp_last_i;
            end else begin
              acc_data_d = merged_data;
              acc_id_d   = merged_id;
              acc_err_d  = merged_err;
              acc_last_d = bus_rsp_last_i;
              state_d    = WAIT;
            end
          end else begin
            acc_data_d = merged_data;
            acc_id_d   = merged_id;
            acc_err_d  = merged_err;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        // The output register is always occupied here; it refills from the
        // parked word in the same cycle it drains.
        if (out_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_data_q;
          out_id_d    = acc_id_q;
          out_err_d   = acc_err_q;
          out_last_d  = acc_last_q;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State registers; reset discards any partial or pending word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FILL;
      acc_data_q  <= '0;
      acc_id_q    <= '0;
      acc_err_q   <= 1'b0;
      acc_last_q  <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_data_q  <= acc_data_d;
      acc_id_q    <= acc_id_d;
      acc_err_q   <= acc_err_d;
      acc_last_q  <= acc_last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
    end
  end

  // Beats of one word must share an ID; the first beat's ID is the one kept.
  id_stable_in_word: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (beat_fire && (cnt_q != '0)) |-> (bus_rsp_id_i == acc_id_q));

endmodule

// File: tb/tb_hpdcache_mem_resp_upsizer.sv
// Bench for hpdcache_mem_resp_upsizer: table of directed transactions, hand-written
// stall and reset sequences, and randomized traffic against a transaction-level model.
module tb_hpdcache_mem_resp_upsizer;
  localparam int IN_W  = 128;
  localparam int OUT_W = 512;
  localparam int ID_W  = 7;
  localparam int RATIO = OUT_W / IN_W;
  localparam int EXP_W = OUT_W + ID_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             bus_valid;
  logic             bus_ready;
  logic [IN_W-1:0]  bus_data;
  logic [ID_W-1:0]  bus_id;
  logic             bus_err;
  logic             bus_last;
  logic             mem_valid;
  logic             mem_ready;
  logic [OUT_W-1:0] mem_data;
  logic [ID_W-1:0]  mem_id;
  logic             mem_err;
  logic             mem_last;

  hpdcache_mem_resp_upsizer #(
    .IN_DATA_WIDTH (IN_W),
    .OUT_DATA_WIDTH(OUT_W),
    .ID_WIDTH      (ID_W)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .bus_rsp_valid_i      (bus_valid),
    .bus_rsp_ready_o      (bus_ready),
    .bus_rsp_data_i       (bus_data),
    .bus_rsp_id_i         (bus_id),
    .bus_rsp_error_i      (bus_err),
    .bus_rsp_last_i       (bus_last),
    .mem_resp_read_valid_o(mem_valid),
    .mem_resp_read_ready_i(mem_ready),
    .mem_resp_read_data_o (mem_data),
    .mem_resp_read_id_o   (mem_id),
    .mem_resp_read_error_o(mem_err),
    .mem_resp_read_last_o (mem_last)
  );

  // ---------------- bookkeeping ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int words_seen = 0;
  int ready_low = 0;
  int beats_acc = 0;
  logic last_word_err = 1'b0;
  logic [IN_W-1:0] beat_buf[64];
  logic beat_err[64];
  logic rand_ready_en = 1'b0;
  logic held = 1'b0;
  logic [EXP_W-1:0] held_word = '0;

  typedef struct {
    logic [ID_W-1:0] id;
    int              nbeats;
    logic [15:0]     err_mask;
    logic [7:0]      pat;
    int              exp_words;
    logic            exp_err;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [EXP_W-1:0] out_word();
    return {mem_last, mem_err, mem_id, mem_data};
  endfunction

  task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction of n beats splits into ceil(n/RATIO) words; beat k of a word lands
  // in lane k, missing lanes are zero, error is the OR over the word's beats, and
  // only the final word is marked last.
  task automatic model_push(input logic [ID_W-1:0] id, input int n);
    logic [OUT_W-1:0] d;
    logic e;
    logic l;
    for (int w = 0; w * RATIO < n; w++) begin
      d = '0;
      e = 1'b0;
      for (int k = 0; k < RATIO; k++) begin
        if (w * RATIO + k < n) begin
          d[k*IN_W +: IN_W] = beat_buf[w*RATIO+k];
          e = e | beat_err[w*RATIO+k];
        end
      end
      l = ((w + 1) * RATIO >= n);
      exp_q.push_back({l, e, id, d});
    end
  endtask

  task automatic fill_pattern(input logic [7:0] pat, input int n, input logic [15:0] err_mask);
    for (int b = 0; b < n; b++) begin
      beat_buf[b] = {16{8'(pat * (b + 1))}};
      beat_err[b] = err_mask[b];
    end
  endtask

  task automatic fill_random(input int n);
    for (int b = 0; b < n; b++) begin
      beat_buf[b] = {$urandom, $urandom, $urandom, $urandom};
      beat_err[b] = ($urandom_range(0, 7) == 0);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic drive_beat(input logic [ID_W-1:0] id, input logic [IN_W-1:0] data,
                            input logic err, input logic last);
    int waited;
    waited = 0;
    bus_valid = 1'b1;
    bus_data  = data;
    bus_id    = id;
    bus_err   = err;
    bus_last  = last;
    forever begin
      @(negedge clk);
      if (bus_ready) break;
      waited++;
      if (waited > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_timeout: got no ready after %0d cycles expected ready", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    beats_acc++;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
  endtask

  task automatic send_txn(input logic [ID_W-1:0] id, input int n, input int gap_max);
    for (int b = 0; b < n; b++) begin
      drive_beat(id, beat_buf[b], beat_err[b], (b == n - 1));
      if (gap_max > 0 && b != n - 1) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !mem_valid) break;
      @(negedge clk);
    end
    check_int("drain", int'(exp_q.size() == 0 && !mem_valid), 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Samples on the falling edge: pops one expected word per output handshake and
  // checks that a stalled word keeps valid high and its payload unchanged.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (!bus_ready) ready_low++;
      if (held) begin
        check_int("hold_valid", int'(mem_valid), 1);
        check("hold_word", out_word(), held_word);
      end
      if (mem_valid && mem_ready) begin
        words_seen++;
        last_word_err = mem_err;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", out_word());
        end else begin
          check("word", out_word(), exp_q.pop_front());
        end
      end
      held = mem_valid && !mem_ready;
      held_word = out_word();
    end
  end

  // Random backpressure on the cache side while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    int r0;
    int n;
    logic [ID_W-1:0] id;

    vecs[0] = '{7'd5,  4, 16'h0000, 8'h11, 1, 1'b0};
    vecs[1] = '{7'd2,  1, 16'h0000, 8'hA5, 1, 1'b0};
    vecs[2] = '{7'd9,  8, 16'h0000, 8'h21, 2, 1'b0};
    vecs[3] = '{7'd3,  4, 16'h0002, 8'h30, 1, 1'b1};
    vecs[4] = '{7'd4,  4, 16'h0000, 8'h40, 1, 1'b0};
    vecs[5] = '{7'd10, 6, 16'h0020, 8'h50, 2, 1'b1};
    vecs[6] = '{7'd11, 3, 16'h0000, 8'h60, 1, 1'b0};

    bus_valid = 1'b0;
    bus_data  = '0;
    bus_id    = '0;
    bus_err   = 1'b0;
    bus_last  = 1'b0;
    mem_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_mem_valid", int'(mem_valid), 0);
    check_int("rst_bus_ready", int'(bus_ready), 1);
    check("rst_word", out_word(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table with the output side always ready.
    for (int i = 0; i < 7; i++) begin
      fill_pattern(vecs[i].pat, vecs[i].nbeats, vecs[i].err_mask);
      model_push(vecs[i].id, vecs[i].nbeats);
      w0 = words_seen;
      r0 = ready_low;
      send_txn(vecs[i].id, vecs[i].nbeats, 0);
      @(negedge clk);
      check_int("latency_valid", int'(mem_valid), 1);
      @(posedge clk);
      #1;
      wait_drain();
      check_int("table_words", words_seen - w0, vecs[i].exp_words);
      check_int("table_last_err", int'(last_word_err), int'(vecs[i].exp_err));
      check_int("table_bus_ready_low", ready_low - r0, 0);
    end

    // Output stalled for 10 cycles while 12 beats are offered.
    mem_ready = 1'b0;
    fill_pattern(8'h07, 12, 16'h0000);
    model_push(7'd12, 12);
    w0 = words_seen;
    beats_acc = 0;
    fork
      send_txn(7'd12, 12, 0);
      begin
        for (int i = 0; i < 60 && beats_acc < 8; i++) @(negedge clk);
        check_int("stall_bus_ready", int'(bus_ready), 0);
        check_int("stall_out_valid", int'(mem_valid), 1);
        check_int("stall_no_words", words_seen - w0, 0);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        mem_ready = 1'b1;
      end
    join
    wait_drain();
    check_int("stall_words", words_seen - w0, 3);

    // Randomized traffic with random gaps and random output backpressure.
    rand_ready_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n  = $urandom_range(1, 3 * RATIO);
      id = ID_W'($urandom_range(0, 127));
      fill_random(n);
      model_push(id, n);
      send_txn(id, n, 2);
    end
    rand_ready_en = 1'b0;
    mem_ready = 1'b1;
    wait_drain();

    // Reset with a word pending at the output and a partial word accumulated.
    mem_ready = 1'b0;
    fill_pattern(8'h3C, 4, 16'h0000);
    send_txn(7'd6, 4, 0);
    fill_pattern(8'h5A, 2, 16'h0000);
    send_txn(7'd7, 2, 0);
    @(negedge clk);
    check_int("pre_reset_valid", int'(mem_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("async_rst_valid", int'(mem_valid), 0);
    check_int("async_rst_bus_ready", int'(bus_ready), 1);
    check("async_rst_word", out_word(), '0);
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_int("post_rst_idle", int'(mem_valid), 0);
    end
    @(posedge clk);
    #1;
    w0 = words_seen;
    fill_pattern(8'h99, 4, 16'h0000);
    model_push(7'd8, 4);
    send_txn(7'd8, 4, 0);
    wait_drain();
    check_int("post_rst_words", words_seen - w0, 1);
    check_int("post_rst_err", int'(last_word_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL global_timeout: got no completion expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/hpdcache_mem_resp_upsizer.md
Name: hpdcache_mem_resp_upsizer

Overview:
- Sits between a narrow system read-response channel and the cache's memory read-response port (`mem_resp_read_*`).
- Collects consecutive narrow beats of one transaction into a full `OUT_DATA_WIDTH` line word.
- Emits the assembled word with its ID, a sticky error flag and a last flag.
- Lets a 512-bit-line cache run on a 128-bit interconnect without changing the cache core.

Parameters:
- IN_DATA_WIDTH, 128, width of a narrow response beat; must divide OUT_DATA_WIDTH.
- OUT_DATA_WIDTH, 512, cache memory data width (memDataWidth).
- ID_WIDTH, 7, transaction ID width (memIdWidth).
- Derived RATIO = OUT_DATA_WIDTH/IN_DATA_WIDTH; must be a power of 2, at least 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- bus_rsp_valid_i  in  1  narrow beat valid
- bus_rsp_ready_o  out  1  narrow beat accepted when valid&ready
- bus_rsp_data_i  in  IN_DATA_WIDTH  beat data
- bus_rsp_id_i  in  ID_WIDTH  beat transaction ID
- bus_rsp_error_i  in  1  beat error
- bus_rsp_last_i  in  1  final beat of transaction
- mem_resp_read_valid_o  out  1  assembled word valid
- mem_resp_read_ready_i  in  1  cache accepts word
- mem_resp_read_data_o  out  OUT_DATA_WIDTH  assembled data
- mem_resp_read_id_o  out  ID_WIDTH  transaction ID
- mem_resp_read_error_o  out  1  OR of beat errors in this word
- mem_resp_read_last_o  out  1  word contains transaction's last beat

Behaviour:
- Single clock clk_i; asynchronous active-low reset rst_ni. Reset clears all registers.
- Reset values:
  - bus_rsp_ready_o = 1
  - mem_resp_read_valid_o = 0
  - data = 0, id = 0, error = 0, last = 0
  - beat counter = 0, state FILL
- Storage: one accumulator (data, id, sticky error, lane counter) plus one output register (the ports).
- Lane placement: beat k of an output word goes to bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]. Lane counter wraps at RATIO.
- Word completion: a beat completes the word when lane counter == RATIO-1 or bus_rsp_last_i=1.
  - A word completed early by last has its unwritten upper lanes forced to 0.
  - last output = bus_rsp_last_i of the completing beat.
  - Transactions longer than RATIO beats produce several words; only the final word has last=1.
- ID and error:
  - ID is captured from the first beat of each word.
  - Error output = OR of error over all beats of the word; it clears on the next word.
- States:
  - FILL: bus_rsp_ready_o=1. A completing beat is written, together with the accumulator contents, directly into the output register if the output register is empty or draining this cycle (mem_resp_read_valid_o & mem_resp_read_ready_i). Otherwise the word stays in the accumulator and the state goes to WAIT.
  - WAIT: bus_rsp_ready_o=0. On an output handshake, the accumulator moves to the output register in the same cycle and the state returns to FILL.
- Latency: the completing beat is accepted at edge N; mem_resp_read_valid_o=1 in cycle N+1. Full throughput is one beat per cycle with no bubbles while mem_resp_read_ready_i=1.
- Output handshake: valid stays asserted and data/id/error/last stay stable until ready. Valid does not drop without a handshake.
- bus_rsp_ready_o is a pure register/state function; it has no combinational path from bus_rsp_valid_i.
- Beats of different transactions do not interleave. An ID change inside an unfinished word is a protocol violation, flagged by a simulation assertion; the RTL keeps the first-beat ID.
- RATIO=1: each beat is a full word; the block degenerates to a one-entry pipeline register with an extra accumulator slot.
- Reset mid-word or while WAIT drops all partial and pending data. No output fires after reset until new beats arrive.

Test Plan:
- 4 beats ID=5, data 0x11..,0x22..,0x33..,0x44.., last on beat 4, ready=1 -> one word in the cycle after beat 4: lanes [0..3]=0x11,0x22,0x33,0x44, id=5, last=1, error=0.
- Single beat ID=2, data 0xA5, last=1 -> word with lane0=0xA5, lanes1-3=0, last=1, valid one cycle later.
- 8-beat burst ID=9, ready=1 -> two words; first last=0, second last=1; bus_rsp_ready_o never deasserts.
- Error on beat 2 of 4 -> error=1 on that word; next transaction's word has error=0.
- mem_resp_read_ready_i=0 for 10 cycles while 12 beats are offered -> first word holds stable. Second word is assembled and bus_rsp_ready_o=0 after its 4th beat. On release, words drain in order with no beat lost or duplicated.
- Assert rst_ni low after 2 beats -> outputs return to reset values asynchronously. A fresh 4-beat transaction afterwards yields exactly one clean word.
